// File: rtl/seq_detector_param.sv
// Serial pattern detector with a parametrised pattern, run-time overlap mode,
// valid-gated input and a saturating match counter. Moore output y.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             clear,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  win_q, win_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              y_q, y_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  win_shift;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;
    logic              sat;

    always_comb begin
        win_shift = {win_q[PAT_W-2:0], din};
        fill_inc  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        // A full window is required, so warm-up garbage never matches.
        hit       = (fill_inc == FILL_FULL) && (win_shift == PATTERN);
        sat       = &cnt_q;
    end

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        y_d    = y_q;
        cnt_d  = cnt_q;
        if (clear) begin
            win_d  = '0;
            fill_d = '0;
            y_d    = 1'b0;
            cnt_d  = '0;
        end else if (din_valid) begin
            win_d = win_shift;
            if (hit) begin
                y_d = 1'b1;
                if (!sat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Non-overlapping mode forces PAT_W fresh bits before the next hit.
                fill_d = overlap ? FILL_FULL : '0;
            end else begin
                y_d    = 1'b0;
                fill_d = fill_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
            y_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
            y_q    <= y_d;
            cnt_q  <= cnt_d;
        end
    end

    assign y         = y_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat;

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector, Moore style, the generalised successor of the fixed 4-bit detectors. It compares a stream of single-bit samples against a compile-time pattern of any width. The overlap mode is selectable at run time, input is gated by a valid strobe, and a saturating match counter is kept. It sits directly on a serial data line, for example a frame-sync or preamble hunt ahead of a deserialiser.

## Interface
- PAT_W, 4: pattern length in bits, legal range 2..32.
- PATTERN, 4'b1011: pattern to detect, PAT_W bits wide; MSB is the first bit received.
- CNT_W, 8: width of the match counter, legal range 1..32.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is accepted on a rising edge only when this is 1.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled with each accepted bit.
- clear  in  1  synchronous flush of window, fill count, y and match_cnt.
- y  out  1  detect flag, registered Moore output.
- match_cnt  out  CNT_W  number of matches since reset/clear; saturates.
- cnt_sat  out  1  1 when match_cnt equals all-ones.

## Operation
- State registers:
  - win[PAT_W-1:0]: shift window; a new bit enters at the LSB and win[PAT_W-1] is the oldest bit.
  - fill: bits accepted since the last flush, saturating at PAT_W, width $clog2(PAT_W+1).
  - y_q: detect flag.
  - match_cnt.
- Accepted bit (din_valid=1, clear=0):
  - win_n = {win[PAT_W-2:0], din}; fill_n = min(fill+1, PAT_W).
  - Hit when fill_n == PAT_W and win_n == PATTERN.
  - On a hit: y_q <= 1 and match_cnt increments unless saturated.
  - Overlapping mode on a hit: win <= win_n, fill <= PAT_W, so trailing bits are reusable.
  - Non-overlapping mode on a hit: fill <= 0; win is don't-care. The next hit needs PAT_W fresh bits.
  - No hit: win <= win_n, fill <= fill_n, y_q <= 0.
- No accepted bit (din_valid=0, clear=0): all state holds, including y. Because y is Moore, it stays high until the next accepted bit.
- clear=1: win, fill, y_q and match_cnt go to 0 on the edge, regardless of din_valid; the din on that edge is discarded.
- Reset values: y=0, match_cnt=0, cnt_sat=0, win=0, fill=0.
- Warm-up: the window contents before fill reaches PAT_W never produce a hit, even if the pattern is all zeros.
- Counter saturation: at all-ones, match_cnt holds and cnt_sat=1; further hits still pulse y.
- A change of overlap between bits affects only the hit decision of the bit it is sampled with.

## Timing
- Latency: y rises on the same rising edge that accepts the completing bit, so it is visible one cycle after din is presented.
- match_cnt updates on that same edge.
- y is high for exactly one cycle when din_valid is held at 1.
  - Back-to-back hits (overlap=1, e.g. PATTERN all ones) keep y high continuously.
- The minimum gap between hits is 1 accepted bit in overlapping mode and PAT_W accepted bits in non-overlapping mode.
- rst assertion clears all state immediately, without waiting for clk. The first bit is accepted on the first rising edge after rst deasserts.
- Mid-operation reset or clear: a partial match is lost and detection restarts from fill=0.
- Outputs are registers only; there is no combinational path from din to y.

## Test plan
- Default parameters, overlap=1, din_valid=1, din 0,1,0,1,1,0,1,1,0,1,0,1,1,0 -> y high after bits 5, 8 and 13; match_cnt=3.
- Same stream with overlap=0 -> y high after bits 5 and 13 only; match_cnt=2.
- PATTERN=4'b1111, eight consecutive 1s:
  - overlap=1 -> y high continuously after bits 4-8; match_cnt=5.
  - overlap=0 -> y high after bits 4 and 8; match_cnt=2.
- Default stream with din_valid=0 inserted for 3 cycles between bits 3 and 4 -> same 3 hits. y held high through a valid gap placed immediately after bit 5.
- CNT_W=2, overlap=1, PATTERN=4'b1111, ten 1s -> match_cnt is 3 and cnt_sat=1 from the 3rd hit on; y still high on every hit.
- Interruptions of the default stream:
  - rst pulse (asynchronous, mid-cycle) after bit 4 -> y=0 and match_cnt=0 immediately; no hit on bit 5.
  - clear with din_valid=1 on bit 4 -> bit 4 discarded; no hit until a fresh 1011.
